hazard_unit: RTL and testbench

Pipeline hazard controller paired with the forwarding unit: forwarding resolves dependencies by bypass, this block stalls and flushes where bypass cannot. It detects load-use and ID-stage branch-operand hazards, holds the pipeline for multi-cycle functional-unit (FU) operations, and kills the wrong-path fetch on a taken branch. It sits beside the decode stage and drives the PC, IF/ID, ID/EX and EX/MEM register enables and flushes.

---
 rtl/hazard_unit_pkg.sv | 23 ++
 rtl/hazard_fu_timer.sv | 63 ++++++
 rtl/hazard_unit.sv | 101 ++++++++++
 tb/tb_hazard_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared encodings, FU timer state type and a source-match helper for the hazard controller.
package hazard_unit_pkg;

  localparam logic [1:0] MD_MEM = 2'b00;
  localparam logic [1:0] MD_FU  = 2'b01;

  localparam int unsigned FU_LAT_MIN = 2;
  localparam int unsigned FU_LAT_MAX = 15;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    FU_BUSY = 1'b1
  } fu_state_e;

  // x0 is hard-wired zero, so it never creates a dependency.
  function automatic logic src_match(input logic [4:0] rs1, input logic uses_rs1,
                                     input logic [4:0] rs2, input logic uses_rs2,
                                     input logic [4:0] rd);
    return (rd != 5'd0) && ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_fu_timer.sv
// Tracks a multi-cycle FU op in EX: start pulse, pipeline hold, done pulse.
module hazard_fu_timer
  import hazard_unit_pkg::*;
#(
  parameter int unsigned FU_LATENCY = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      multi_cycle,
  output logic      fu_start,
  output logic      fu_done,
  output logic      fu_hold,
  output fu_state_e state_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FU_LATENCY - 2);

  fu_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Outputs depend on the current state and the live EX input so the first
  // hold cycle coincides with the op entering EX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fu_start = 1'b0;
    fu_done  = 1'b0;
    fu_hold  = 1'b0;
    case (state_q)
      IDLE: begin
        if (multi_cycle) begin
          fu_start = 1'b1;
          fu_hold  = 1'b1;
          state_d  = FU_BUSY;
          cnt_d    = CNT_INIT;
        end
      end
      FU_BUSY: begin
        if (cnt_q != '0) begin
          fu_hold = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          fu_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller: load-use, ID-branch operand hazards, multi-cycle FU hold, taken-branch flush.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned FU_LATENCY  = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             IfIdRegRs1,
  input  logic [4:0]             IfIdRegRs2,
  input  logic                   IfIdUsesRs1,
  input  logic                   IfIdUsesRs2,
  input  logic                   IfIdBranch,
  input  logic                   BranchTaken,
  input  logic [4:0]             IdExeRegRd,
  input  logic                   IdExeRegWrite,
  input  logic [1:0]             IdExeMD,
  input  logic                   IdExeMultiCycle,
  input  logic [4:0]             ExeMemRegRd,
  input  logic                   ExeMemRegWrite,
  input  logic [1:0]             ExeMemMD,
  output logic                   PcWrite,
  output logic                   IfIdWrite,
  output logic                   IdExeWrite,
  output logic                   IfIdFlush,
  output logic                   IdExeFlush,
  output logic                   ExeMemFlush,
  output logic                   FuStart,
  output logic                   FuDone,
  output logic [STALL_CNT_W-1:0] StallCount,
  output fu_state_e              FuState
);

  logic fu_start, fu_done, fu_hold;
  logic ex_match, mem_match, load_use, branch_dep;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  hazard_fu_timer #(.FU_LATENCY(FU_LATENCY)) u_fu_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .multi_cycle (IdExeMultiCycle),
    .fu_start    (fu_start),
    .fu_done     (fu_done),
    .fu_hold     (fu_hold),
    .state_o     (FuState)
  );

  assign ex_match  = src_match(IfIdRegRs1, IfIdUsesRs1, IfIdRegRs2, IfIdUsesRs2, IdExeRegRd);
  assign mem_match = src_match(IfIdRegRs1, IfIdUsesRs1, IfIdRegRs2, IfIdUsesRs2, ExeMemRegRd);

  assign load_use = IdExeRegWrite && (IdExeMD == MD_MEM) && ex_match;

  // An ID-resolved branch cannot take any bypass from EX, and a load result
  // in MEM is not available until WB.
  assign branch_dep = IfIdBranch &&
                      ((IdExeRegWrite && ex_match) ||
                       (ExeMemRegWrite && (ExeMemMD == MD_MEM) && mem_match));

  always_comb begin
    PcWrite     = 1'b1;
    IfIdWrite   = 1'b1;
    IdExeWrite  = 1'b1;
    IfIdFlush   = 1'b0;
    IdExeFlush  = 1'b0;
    ExeMemFlush = 1'b0;
    FuStart     = fu_start;
    FuDone      = fu_done;
    if (fu_hold) begin
      // EX keeps its op; MEM receives bubbles while the FU works.
      PcWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      IdExeWrite  = 1'b0;
      ExeMemFlush = 1'b1;
    end else if (load_use || branch_dep) begin
      PcWrite    = 1'b0;
      IfIdWrite  = 1'b0;
      IdExeFlush = 1'b1;
    end else if (BranchTaken) begin
      IfIdFlush = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!PcWrite && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scenario bench for hazard_unit: scoreboard of expected output vectors per cycle.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IfIdRegRs1, IfIdRegRs2, IdExeRegRd, ExeMemRegRd;
  logic        IfIdUsesRs1, IfIdUsesRs2, IfIdBranch, BranchTaken;
  logic        IdExeRegWrite, IdExeMultiCycle, ExeMemRegWrite;
  logic [1:0]  IdExeMD, ExeMemMD;
  logic        PcWrite, IfIdWrite, IdExeWrite, IfIdFlush, IdExeFlush, ExeMemFlush, FuStart, FuDone;
  logic [15:0] StallCount;
  fu_state_e   FuState;
  logic        s_pc, s_ifid, s_idex, s_ifidf, s_idexf, s_exmf, s_start, s_done;
  logic [3:0]  sat_count;
  fu_state_e   sat_state;

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  logic [3:0]  sat_q[$];
  logic [15:0] exp_cnt;

  // {PcWrite, IfIdWrite, IdExeWrite, IfIdFlush, IdExeFlush, ExeMemFlush, FuStart, FuDone}
  localparam logic [7:0] V_NONE = 8'b111_000_00;
  localparam logic [7:0] V_LU   = 8'b001_010_00;
  localparam logic [7:0] V_BRF  = 8'b111_100_00;
  localparam logic [7:0] V_HS   = 8'b000_001_10;
  localparam logic [7:0] V_HOLD = 8'b000_001_00;
  localparam logic [7:0] V_DONE = 8'b111_000_01;

  always #5 clk = ~clk;

  hazard_unit #(.FU_LATENCY(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .IfIdRegRs1(IfIdRegRs1), .IfIdRegRs2(IfIdRegRs2),
    .IfIdUsesRs1(IfIdUsesRs1), .IfIdUsesRs2(IfIdUsesRs2),
    .IfIdBranch(IfIdBranch), .BranchTaken(BranchTaken),
    .IdExeRegRd(IdExeRegRd), .IdExeRegWrite(IdExeRegWrite), .IdExeMD(IdExeMD),
    .IdExeMultiCycle(IdExeMultiCycle),
    .ExeMemRegRd(ExeMemRegRd), .ExeMemRegWrite(ExeMemRegWrite), .ExeMemMD(ExeMemMD),
    .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IdExeWrite(IdExeWrite),
    .IfIdFlush(IfIdFlush), .IdExeFlush(IdExeFlush), .ExeMemFlush(ExeMemFlush),
    .FuStart(FuStart), .FuDone(FuDone), .StallCount(StallCount), .FuState(FuState)
  );

  hazard_unit #(.FU_LATENCY(4), .STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .IfIdRegRs1(IfIdRegRs1), .IfIdRegRs2(IfIdRegRs2),
    .IfIdUsesRs1(IfIdUsesRs1), .IfIdUsesRs2(IfIdUsesRs2),
    .IfIdBranch(IfIdBranch), .BranchTaken(BranchTaken),
    .IdExeRegRd(IdExeRegRd), .IdExeRegWrite(IdExeRegWrite), .IdExeMD(IdExeMD),
    .IdExeMultiCycle(IdExeMultiCycle),
    .ExeMemRegRd(ExeMemRegRd), .ExeMemRegWrite(ExeMemRegWrite), .ExeMemMD(ExeMemMD),
    .PcWrite(s_pc), .IfIdWrite(s_ifid), .IdExeWrite(s_idex),
    .IfIdFlush(s_ifidf), .IdExeFlush(s_idexf), .ExeMemFlush(s_exmf),
    .FuStart(s_start), .FuDone(s_done), .StallCount(sat_count), .FuState(sat_state)
  );

  task automatic idle_inputs();
    IfIdRegRs1 = '0; IfIdRegRs2 = '0; IfIdUsesRs1 = 0; IfIdUsesRs2 = 0;
    IfIdBranch = 0; BranchTaken = 0;
    IdExeRegRd = '0; IdExeRegWrite = 0; IdExeMD = MD_FU; IdExeMultiCycle = 0;
    ExeMemRegRd = '0; ExeMemRegWrite = 0; ExeMemMD = MD_FU;
  endtask

  function automatic logic [23:0] obs();
    return {PcWrite, IfIdWrite, IdExeWrite, IfIdFlush, IdExeFlush, ExeMemFlush,
            FuStart, FuDone, StallCount};
  endfunction

  // Scoreboard push: the counter is expected to advance after every cycle with PcWrite low.
  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back({v, exp_cnt});
    if (!v[7]) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    logic [23:0] got, exp;
    rst_n = 1'b0;
    idle_inputs();
    exp_cnt = '0;
    @(negedge clk);
    push_exp(V_NONE);
    got = obs(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset got=%h exp=%h", got, exp); end
    checks++;
    if (FuState !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", FuState, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    logic [23:0] got, exp;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (c == 0) begin
        IdExeRegWrite = 1; IdExeMD = MD_MEM; IdExeRegRd = 5'd5;
        IfIdRegRs1 = 5'd5; IfIdUsesRs1 = 1;
        push_exp(V_LU);
      end else begin
        ExeMemRegWrite = 1; ExeMemMD = MD_MEM; ExeMemRegRd = 5'd5;
        IfIdRegRs1 = 5'd5; IfIdUsesRs1 = 1;
        push_exp(V_NONE);
      end
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL load_use c%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task automatic test_no_stall();
    logic [23:0] got, exp;
    logic lu;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      IdExeRegWrite = 1; IdExeMD = MD_MEM; IdExeRegRd = 5'd5;
      case (c)
        0: begin IdExeRegRd = 5'd0; IfIdRegRs1 = 5'd0; IfIdUsesRs1 = 1; push_exp(V_NONE); end
        1: begin IfIdRegRs1 = 5'd5; IfIdUsesRs1 = 0; push_exp(V_NONE); end
        2: begin IfIdRegRs2 = 5'd5; IfIdUsesRs2 = 1; push_exp(V_LU); end
        3: begin IdExeMD = MD_FU; IfIdRegRs1 = 5'd5; IfIdUsesRs1 = 1; push_exp(V_NONE); end
        4: begin IdExeRegWrite = 0; IfIdRegRs1 = 5'd5; IfIdUsesRs1 = 1; push_exp(V_NONE); end
        default: begin
          IfIdRegRs1 = 5'($urandom_range(0, 3)); IfIdRegRs2 = 5'($urandom_range(0, 3));
          IfIdUsesRs1 = 1'($urandom_range(0, 1)); IfIdUsesRs2 = 1'($urandom_range(0, 1));
          IdExeRegRd = 5'($urandom_range(0, 3)); IdExeRegWrite = 1'($urandom_range(0, 1));
          IdExeMD = 2'($urandom_range(0, 1));
          lu = IdExeRegWrite && (IdExeMD == 2'b00) && (IdExeRegRd != 0) &&
               ((IfIdUsesRs1 && IfIdRegRs1 == IdExeRegRd) || (IfIdUsesRs2 && IfIdRegRs2 == IdExeRegRd));
          push_exp(lu ? V_LU : V_NONE);
        end
      endcase
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL no_stall c%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task automatic test_branch_dep();
    logic [23:0] got, exp;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      IfIdBranch = (c != 5);
      case (c)
        0: begin IfIdRegRs1 = 5'd7; IfIdUsesRs1 = 1; BranchTaken = 1;
                 IdExeRegWrite = 1; IdExeMD = MD_MEM; IdExeRegRd = 5'd7; push_exp(V_LU); end
        1: begin IfIdRegRs1 = 5'd7; IfIdUsesRs1 = 1; BranchTaken = 1;
                 ExeMemRegWrite = 1; ExeMemMD = MD_MEM; ExeMemRegRd = 5'd7; push_exp(V_LU); end
        2: begin IfIdRegRs1 = 5'd7; IfIdUsesRs1 = 1; BranchTaken = 1; push_exp(V_BRF); end
        3: begin IfIdRegRs2 = 5'd7; IfIdUsesRs2 = 1;
                 IdExeRegWrite = 1; IdExeMD = MD_FU; IdExeRegRd = 5'd7; push_exp(V_LU); end
        4: begin IfIdRegRs2 = 5'd7; IfIdUsesRs2 = 1; BranchTaken = 1;
                 ExeMemRegWrite = 1; ExeMemMD = MD_FU; ExeMemRegRd = 5'd7; push_exp(V_BRF); end
        default: push_exp(V_NONE);
      endcase
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL branch_dep c%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task automatic test_fu(input int ops, input string name);
    logic [23:0] got, exp;
    logic [7:0] seq [4];
    seq[0] = V_HS; seq[1] = V_HOLD; seq[2] = V_HOLD; seq[3] = V_DONE;
    for (int c = 0; c < ops * 4 + 1; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (c < ops * 4) begin
        IdExeMultiCycle = 1; IdExeRegWrite = 1; IdExeMD = MD_FU; IdExeRegRd = 5'd9;
        push_exp(seq[c % 4]);
      end else begin
        push_exp(V_NONE);
      end
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL %s c%0d got=%h exp=%h", name, c, got, exp); end
    end
  endtask

  task automatic test_fu_priority();
    logic [23:0] got, exp;
    logic [7:0] seq [4];
    seq[0] = V_HS; seq[1] = V_HOLD; seq[2] = V_HOLD; seq[3] = V_DONE;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      IdExeMultiCycle = 1; IdExeRegWrite = 1; IdExeMD = MD_MEM; IdExeRegRd = 5'd5;
      IfIdRegRs1 = 5'd5; IfIdUsesRs1 = 1; IfIdBranch = 1; BranchTaken = 1;
      push_exp(c == 0 ? V_HS : V_HOLD);
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL fu_priority c%0d got=%h exp=%h", c, got, exp); end
    end
    // Reset in the middle of the hold: outputs and counter clear without a clock edge.
    #2;
    rst_n = 1'b0;
    idle_inputs();
    exp_cnt = '0;
    push_exp(V_NONE);
    #1;
    got = obs(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_hold_reset got=%h exp=%h", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      IdExeMultiCycle = 1; IdExeRegWrite = 1; IdExeMD = MD_FU; IdExeRegRd = 5'd9;
      push_exp(seq[c]);
      @(negedge clk);
      got = obs(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL post_reset_fu c%0d got=%h exp=%h", c, got, exp); end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_s;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (c < 20) begin
        IdExeRegWrite = 1; IdExeMD = MD_MEM; IdExeRegRd = 5'd3;
        IfIdRegRs1 = 5'd3; IfIdUsesRs1 = 1;
      end
      sat_q.push_back(c > 15 ? 4'd15 : 4'(c));
      @(negedge clk);
      exp_s = sat_q.pop_front(); checks++;
      if (sat_count !== exp_s) begin
        failures++; $display("FAIL saturation c%0d got=%0d exp=%0d", c, sat_count, exp_s);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_dep();
    test_fu(1, "fu_single");
    test_fu(2, "fu_back_to_back");
    test_fu_priority();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
